ga_com_req_rx: RTL

- Receiving end of the open/close command handshake from the 125 MHz control domain into the 200 MHz acquisition domain; runs entirely on Ga_clk200.
- Each command arrives as a four-phase req level. Per channel the block synchronizes, debounces and delays the req, issues one single-cycle command pulse and returns an ack level for the sender to synchronize.
- Also maintains the resulting gate state and counts protocol errors.

---
 rtl/ga_com_req_rx.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/ga_com_req_rx.sv
// Open/close command handshake receiver on the 200 MHz acquisition clock.
// Optional ack timeout with WAIT_LOW recovery is enabled by defining GA_RX_TIMEOUT_EN.
module ga_com_req_rx #(
   parameter int unsigned VAL_DEL  = 4,
   parameter int unsigned VAL_DEB  = 3,
   parameter int unsigned SYNC_STG = 2
`ifdef GA_RX_TIMEOUT_EN
   ,
   parameter int unsigned TMO_W    = 16
`endif
) (
   input  logic       Ga_clk200,
   input  logic       Ga_rst_n,
   input  logic       Ga_open_req,
   input  logic       Ga_close_req,
   output logic       Ga_open_ack,
   output logic       Ga_close_ack,
   output logic       Ga_com_open,
   output logic       Ga_com_close,
   output logic       Ga_com_state,
   output logic       Ga_err,
   output logic [7:0] Ga_err_cnt
);

   localparam int unsigned NCH   = 2;   // channel 0 = open, 1 = close
   localparam int unsigned DEL_W = (VAL_DEL < 1) ? 1 : $clog2(VAL_DEL + 1);
   localparam int unsigned DEB_W = (VAL_DEB < 2) ? 1 : $clog2(VAL_DEB);

`ifdef GA_RX_TIMEOUT_EN
   typedef enum logic [1:0] {IDLE, DELAY, ACKED, WAIT_LOW} state_t;
`else
   typedef enum logic [1:0] {IDLE, DELAY, ACKED} state_t;
`endif

   logic [NCH-1:0]      req;
   logic [SYNC_STG-1:0] sync_q [NCH];
   logic [DEB_W-1:0]    deb_q  [NCH];
   logic [DEB_W-1:0]    deb_d  [NCH];
   logic [NCH-1:0]      filt_q, filt_d;
   logic [NCH-1:0]      rise_c, fall_c;

   state_t              state_q [NCH];
   state_t              state_d [NCH];
   logic [DEL_W-1:0]    dly_q   [NCH];
   logic [DEL_W-1:0]    dly_d   [NCH];
   logic [NCH-1:0]      ack_q, ack_d;
   logic [NCH-1:0]      fire_c, abort_c, tmo_c;
`ifdef GA_RX_TIMEOUT_EN
   logic [TMO_W-1:0]    tmo_q   [NCH];
   logic [TMO_W-1:0]    tmo_d   [NCH];
`endif

   logic                com_open_q, com_close_q, com_state_q, err_q;
   logic [7:0]          err_cnt_q;
   logic                err_c;

   assign req = {Ga_close_req, Ga_open_req};

   // Debounce: filtered level flips after VAL_DEB consecutive differing synced samples.
   always_comb begin
      filt_d = filt_q;
      rise_c = '0;
      fall_c = '0;
      for (int i = 0; i < NCH; i++) begin
         deb_d[i] = '0;
         if (sync_q[i][SYNC_STG-1] != filt_q[i]) begin
            if (deb_q[i] == DEB_W'(VAL_DEB - 1)) begin
               filt_d[i] = ~filt_q[i];
               rise_c[i] = ~filt_q[i];
               fall_c[i] = filt_q[i];
            end else begin
               deb_d[i] = deb_q[i] + DEB_W'(1);
            end
         end
      end
   end

   // Channel FSMs react to the filter toggle in the same cycle it happens.
   always_comb begin
      fire_c  = '0;
      abort_c = '0;
      tmo_c   = '0;
      ack_d   = ack_q;
      for (int i = 0; i < NCH; i++) begin
         state_d[i] = state_q[i];
         dly_d[i]   = dly_q[i];
`ifdef GA_RX_TIMEOUT_EN
         tmo_d[i]   = '0;
`endif
         case (state_q[i])
            IDLE: begin
               if (rise_c[i]) begin
                  if (VAL_DEL == 0) begin
                     fire_c[i]  = 1'b1;
                     ack_d[i]   = 1'b1;
                     state_d[i] = ACKED;
                  end else begin
                     dly_d[i]   = DEL_W'(VAL_DEL);
                     state_d[i] = DELAY;
                  end
               end
            end
            DELAY: begin
               if (fall_c[i]) begin
                  abort_c[i] = 1'b1;
                  state_d[i] = IDLE;
               end else if (dly_q[i] == DEL_W'(1)) begin
                  fire_c[i]  = 1'b1;
                  ack_d[i]   = 1'b1;
                  state_d[i] = ACKED;
               end else begin
                  dly_d[i] = dly_q[i] - DEL_W'(1);
               end
            end
            ACKED: begin
               if (fall_c[i]) begin
                  ack_d[i]   = 1'b0;
                  state_d[i] = IDLE;
               end
`ifdef GA_RX_TIMEOUT_EN
               else if (tmo_q[i] == {{(TMO_W-1){1'b1}}, 1'b0}) begin
                  tmo_c[i]   = 1'b1;
                  ack_d[i]   = 1'b0;
                  state_d[i] = WAIT_LOW;
               end else begin
                  tmo_d[i] = tmo_q[i] + TMO_W'(1);
               end
`endif
            end
`ifdef GA_RX_TIMEOUT_EN
            WAIT_LOW: begin
               if (fall_c[i]) begin
                  state_d[i] = IDLE;
               end
            end
`endif
            default: begin
               state_d[i] = IDLE;
               ack_d[i]   = 1'b0;
            end
         endcase
      end
      // Simultaneous fire: close wins, open still acks, flagged as an error.
      err_c = (|abort_c) | (|tmo_c) | (fire_c[0] & fire_c[1]);
   end

   always_ff @(posedge Ga_clk200 or negedge Ga_rst_n) begin
      if (!Ga_rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            sync_q[i]  <= '0;
            deb_q[i]   <= '0;
            dly_q[i]   <= '0;
            state_q[i] <= IDLE;
`ifdef GA_RX_TIMEOUT_EN
            tmo_q[i]   <= '0;
`endif
         end
         filt_q      <= '0;
         ack_q       <= '0;
         com_open_q  <= 1'b0;
         com_close_q <= 1'b0;
         com_state_q <= 1'b0;
         err_q       <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            sync_q[i]  <= {sync_q[i][SYNC_STG-2:0], req[i]};
            deb_q[i]   <= deb_d[i];
            dly_q[i]   <= dly_d[i];
            state_q[i] <= state_d[i];
`ifdef GA_RX_TIMEOUT_EN
            tmo_q[i]   <= tmo_d[i];
`endif
         end
         filt_q      <= filt_d;
         ack_q       <= ack_d;
         com_open_q  <= fire_c[0] & ~fire_c[1];
         com_close_q <= fire_c[1];
         err_q       <= err_c;
         if (com_open_q) begin
            com_state_q <= 1'b1;
         end else if (com_close_q) begin
            com_state_q <= 1'b0;
         end
         if (err_c && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
         end
      end
   end

   assign Ga_open_ack  = ack_q[0];
   assign Ga_close_ack = ack_q[1];
   assign Ga_com_open  = com_open_q;
   assign Ga_com_close = com_close_q;
   assign Ga_com_state = com_state_q;
   assign Ga_err       = err_q;
   assign Ga_err_cnt   = err_cnt_q;

endmodule
